cla_serial_ctrl: RTL



---
 rtl/cla_serial_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cla_serial_ctrl.sv
// ---------------------------------------------------------------------------
// cla_serial_ctrl
//
// Performs a WIDTH-bit addition by stepping one shared 4-bit carry-lookahead
// adder slice across the operands, least-significant nibble first. A
// registered carry links consecutive nibbles, so a WIDTH-bit add takes
// WIDTH/4 RUN cycles plus one DONE cycle.
//
// Optional feature macro: CLA_SUB_EN
//   defined   : adds the 'sub' input and 'ovf' output; sub=1 computes a-b
//               by inverting each B nibble and forcing the initial carry to 1.
//   undefined : pure addition a + b + cin.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request, honoured only while idle
//   a      in   WIDTH  operand A, captured when start is accepted
//   b      in   WIDTH  operand B, captured when start is accepted
//   cin    in   1      carry-in to nibble 0, captured when start is accepted
//   sub    in   1      subtract request (CLA_SUB_EN only)
//   busy   out  1      high while an operation is in RUN or DONE
//   done   out  1      one-cycle pulse, result valid
//   sum    out  WIDTH  result register
//   cout   out  1      carry out of the top nibble
//   ovf    out  1      signed overflow (CLA_SUB_EN only)
// ---------------------------------------------------------------------------
module cla_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SUB_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int SHW  = IDXW + 2;

    // Reject unusable widths at elaboration time.
    generate
        if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("cla_serial_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 4-bit carry-lookahead slice: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    state_t            state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              sub_r;
    logic              carry_r;
    logic [IDXW-1:0]   idx_r;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r;
    logic              busy_r;
    logic              done_r;
`ifdef CLA_SUB_EN
    logic              ovf_r;
`endif

    logic              sub_s;
    logic [SHW-1:0]    sh_s;
    logic [3:0]        a_nib_s;
    logic [3:0]        b_nib_s;
    logic [4:0]        cla_s;
    logic [WIDTH-1:0]  sum_next_s;
    logic              last_s;
`ifdef CLA_SUB_EN
    logic              ovf_s;
`endif

`ifdef CLA_SUB_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    // Nibble selection, CLA evaluation and merge of the new nibble into sum.
    always_comb begin
        sh_s       = {idx_r, 2'b00};
        a_nib_s    = 4'(a_r >> sh_s);
        // Subtraction inverts B one nibble at a time, right at the adder input.
        b_nib_s    = sub_r ? ~(4'(b_r >> sh_s)) : 4'(b_r >> sh_s);
        cla_s      = cla4(a_nib_s, b_nib_s, carry_r);
        sum_next_s = (sum_r & ~(WIDTH'(4'hF) << sh_s))
                   | (WIDTH'(cla_s[3:0]) << sh_s);
        last_s     = (idx_r == IDXW'(NIB - 1));
`ifdef CLA_SUB_EN
        // Only meaningful on the top nibble, where cla_s[3] is sum[WIDTH-1].
        ovf_s      = (a_r[WIDTH-1] == (sub_r ? ~b_r[WIDTH-1] : b_r[WIDTH-1]))
                   && (cla_s[3] != a_r[WIDTH-1]);
`endif
    end

    // Sequencer FSM with all datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef CLA_SUB_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        sub_r   <= sub_s;
                        // Subtract forces the initial carry (two's complement +1).
                        carry_r <= sub_s | cin;
                        idx_r   <= {IDXW{1'b0}};
                        sum_r   <= {WIDTH{1'b0}};
                        cout_r  <= 1'b0;
`ifdef CLA_SUB_EN
                        ovf_r   <= 1'b0;
`endif
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_r   <= sum_next_s;
                    carry_r <= cla_s[4];
                    if (last_s) begin
                        idx_r   <= {IDXW{1'b0}};
                        cout_r  <= cla_s[4];
`ifdef CLA_SUB_EN
                        ovf_r   <= ovf_s;
`endif
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here; no queuing.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
`ifdef CLA_SUB_EN
    assign ovf  = ovf_r;
`endif

endmodule
